// File: rtl/cdc_fifo_pkg.sv
// Shared definitions for the cdc_fifo read-side serial drain path.
// Holds the consumer state encoding and the UART line levels so the
// transmit block and a future receive-side feeder agree on them.
package cdc_fifo_pkg;

    // Consumer sequencing states. PARITY is only entered when the
    // CDC_FIFO_READ_UART_TX_PARITY_EN build option is defined.
    typedef enum logic [2:0] {
        FETCH_LO,
        GAP_LO,
        FETCH_HI,
        GAP_HI,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Line level while nothing is being sent.
    localparam logic UART_IDLE  = 1'b1;

    // Line level of the start bit that opens every frame.
    localparam logic UART_START = 1'b0;

endpackage

// File: rtl/uart_bit_timer.sv
// Serial bit timer: counts CLKS_PER_BIT clock cycles per bit and flags
// the last cycle of each bit. A restart pulse realigns the count so the
// cycle after the pulse is cycle 0 of a new bit. Shared by the UART
// transmit drain and the planned receive-side feeder.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic bit_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] clk_cnt;

    // Free-running cycle counter that wraps at CLKS_PER_BIT-1.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            clk_cnt <= '0;
        end else if (clk_cnt == LAST_CNT) begin
            clk_cnt <= '0;
        end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
        end
    end

    // NOTE: bit_done is decoded from the registered count, so it is glitch-free
    // in the clock domain and lets the consumer act on the very edge that ends
    // the bit instead of one cycle later.
    assign bit_done = (clk_cnt == LAST_CNT);

endmodule

// File: rtl/cdc_fifo_read_uart_tx.sv
// Read-side drain for the cdc_fifo: pops nibbles in pairs (first pop is
// the low nibble), packs them into a byte and sends it LSB-first as a
// UART frame on tx. Everything runs on read_clock with a synchronous,
// active-high read_reset.
// Build option: define CDC_FIFO_READ_UART_TX_PARITY_EN to insert an even
// parity bit between the data bits and the stop bit (8E1 instead of 8N1).
module cdc_fifo_read_uart_tx
    import cdc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  read_clock,
    input  logic                  read_reset,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_increment,
    output logic                  tx,
    output logic                  busy
);

    localparam int BYTE_W = 2 * DATA_WIDTH;
    localparam int BIT_W  = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BYTE_W - 1);

    state_t                  state;
    logic [DATA_WIDTH-1:0]   lo;
    logic [DATA_WIDTH-1:0]   hi;
    logic [BYTE_W-1:0]       shift_reg;
    logic [BIT_W-1:0]        bit_cnt;
    logic                    bit_done;
    logic                    timer_restart;
`ifdef CDC_FIFO_READ_UART_TX_PARITY_EN
    logic                    parity_bit;
`endif

    // The start bit begins on the edge that leaves GAP_HI, so the timer is
    // realigned there and every later bit boundary falls on bit_done.
    assign timer_restart = (state == GAP_HI);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (read_clock),
        .reset    (read_reset),
        .restart  (timer_restart),
        .bit_done (bit_done)
    );

    // Single sequencer: fetches two nibbles with a gap cycle after each pop,
    // then serialises the packed byte. All outputs are registered here.
    always_ff @(posedge read_clock) begin
        // NOTE: every state register uses non-blocking assignment so all of
        // them see the pre-edge values; a blocking write here would let later
        // lines in this block observe the new state within the same edge.
        if (read_reset) begin
            state          <= FETCH_LO;
            read_increment <= 1'b0;
            tx             <= UART_IDLE;
            busy           <= 1'b0;
            lo             <= '0;
            hi             <= '0;
            shift_reg      <= '0;
            bit_cnt        <= '0;
`ifdef CDC_FIFO_READ_UART_TX_PARITY_EN
            parity_bit     <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH_LO: begin
                    if (!empty) begin
                        lo             <= read_data;
                        read_increment <= 1'b1;
                        busy           <= 1'b1;
                        state          <= GAP_LO;
                    end
                end

                // The pop lands at the end of this cycle; the FIFO's empty
                // flag is only trustworthy again in FETCH_HI.
                GAP_LO: begin
                    read_increment <= 1'b0;
                    state          <= FETCH_HI;
                end

                // Waits without a timeout for the second nibble, holding lo.
                FETCH_HI: begin
                    if (!empty) begin
                        hi             <= read_data;
                        read_increment <= 1'b1;
                        state          <= GAP_HI;
                    end
                end

                GAP_HI: begin
                    read_increment <= 1'b0;
                    shift_reg      <= {hi, lo};
                    bit_cnt        <= '0;
                    tx             <= UART_START;
`ifdef CDC_FIFO_READ_UART_TX_PARITY_EN
                    parity_bit     <= ^{hi, lo};
`endif
                    state          <= START;
                end

                START: begin
                    if (bit_done) begin
                        tx    <= shift_reg[0];
                        state <= DATA;
                    end
                end

                // shift_reg[0] is the bit on the line; shift_reg[1] is next.
                DATA: begin
                    if (bit_done) begin
                        if (bit_cnt == LAST_BIT) begin
`ifdef CDC_FIFO_READ_UART_TX_PARITY_EN
                            tx    <= parity_bit;
                            state <= PARITY;
`else
                            tx    <= UART_IDLE;
                            state <= STOP;
`endif
                        end else begin
                            bit_cnt   <= bit_cnt + BIT_W'(1);
                            shift_reg <= {1'b0, shift_reg[BYTE_W-1:1]};
                            tx        <= shift_reg[1];
                        end
                    end
                end

`ifdef CDC_FIFO_READ_UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        tx    <= UART_IDLE;
                        state <= STOP;
                    end
                end
`endif

                STOP: begin
                    if (bit_done) begin
                        busy  <= 1'b0;
                        state <= FETCH_LO;
                    end
                end

                // Unused encodings recover to a clean idle.
                default: begin
                    read_increment <= 1'b0;
                    tx             <= UART_IDLE;
                    busy           <= 1'b0;
                    state          <= FETCH_LO;
                end
            endcase
        end
    end

endmodule
